// File: rtl/control_sumador.sv
// Sequencer that performs a wide addition on one registered 4-bit adder slice.
// It works one nibble per two cycles, least-significant nibble first, and pulses DONE.
module control_sumador #(
    parameter int         N_NIBBLES = 4,
    parameter logic [1:0] MODO_SUMA = 2'b00
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic [4*N_NIBBLES-1:0]   OPA,
    input  logic [4*N_NIBBLES-1:0]   OPB,
    input  logic                     CIN,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [4*N_NIBBLES-1:0]   RESULT,
    output logic                     COUT,
    output logic                     ENB,
    output logic [1:0]               MODO,
    output logic [3:0]               A,
    output logic [3:0]               B,
    output logic                     RCI,
    input  logic [3:0]               Q,
    input  logic                     RCO
);

    localparam int W     = 4 * N_NIBBLES;
    localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EJECUTA = 2'd1,
        ESPERA  = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [W-1:0]     opa_r;
    logic [W-1:0]     opb_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Slice drive is decoded from state only, so START/OPA/OPB never reach outputs combinationally.
    always_comb begin
        state_nx = state;
        ENB      = 1'b0;
        A        = 4'd0;
        B        = 4'd0;
        RCI      = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nx = EJECUTA;
                end
            end
            EJECUTA: begin
                ENB      = 1'b1;
                A        = opa_r[{idx, 2'b00} +: 4];
                B        = opb_r[{idx, 2'b00} +: 4];
                RCI      = carry_r;
                state_nx = ESPERA;
            end
            ESPERA: begin
                state_nx = (idx == IDX_LAST) ? FIN : EJECUTA;
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);
    assign MODO = MODO_SUMA;

    // ESPERA follows the slice's capture edge, so Q/RCO already hold this nibble's sum.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            opa_r   <= '0;
            opb_r   <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            RESULT  <= '0;
            COUT    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        opa_r   <= OPA;
                        opb_r   <= OPB;
                        carry_r <= CIN;
                        idx     <= '0;
                        RESULT  <= '0;
                        COUT    <= 1'b0;
                    end
                end
                ESPERA: begin
                    RESULT[{idx, 2'b00} +: 4] <= Q;
                    carry_r                   <= RCO;
                    if (idx == IDX_LAST) begin
                        COUT <= RCO;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sumador.sv
// Bench for control_sumador: a behavioural 4-bit slice plus a wide-arithmetic reference model.
module tb_control_sumador;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic [W-1:0] OPA;
    logic [W-1:0] OPB;
    logic         CIN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic         COUT;
    logic         ENB;
    logic [1:0]   MODO;
    logic [3:0]   A;
    logic [3:0]   B;
    logic         RCI;
    logic [3:0]   Q = 4'd0;
    logic         RCO = 1'b0;

    int checks   = 0;
    int failures = 0;

    control_sumador #(.N_NIBBLES(N), .MODO_SUMA(2'b00)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT),
        .ENB(ENB), .MODO(MODO), .A(A), .B(B), .RCI(RCI), .Q(Q), .RCO(RCO)
    );

    always #5 CLK = ~CLK;

    // Adder slice: registers {RCO,Q} = A+B+RCI when enabled in add mode.
    always @(posedge CLK) begin
        if (ENB && MODO == 2'b00) begin
            {RCO, Q} <= {1'b0, A} + {1'b0, B} + {4'd0, RCI};
        end
    end

    // Starts an operation from IDLE at a falling edge and returns at the falling edge inside the DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string tag);
        logic [W:0]      sum;
        logic [3:0]      aq[$];
        logic [3:0]      bq[$];
        logic            rq[$];
        int              cyc;
        bit              seen;
        longint unsigned mask;
        longint unsigned cr;
        sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        START = 1'b1;
        OPA   = a;
        OPB   = b;
        CIN   = c;
        cyc   = 0;
        seen  = 0;
        while (!seen && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (ENB) begin
                aq.push_back(A);
                bq.push_back(B);
                rq.push_back(RCI);
            end
            if (DONE) seen = 1;
            START = 1'b0;
            OPA   = W'($urandom);
            OPB   = W'($urandom);
            CIN   = 1'($urandom);
        end
        checks++;
        if (cyc !== 2 * N + 1) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles want %0d", tag, cyc, 2 * N + 1);
        end
        checks++;
        if (RESULT !== sum[W-1:0] || COUT !== sum[W]) begin
            failures++;
            $display("FAIL %s result: got %h/%b want %h/%b", tag, RESULT, COUT, sum[W-1:0], sum[W]);
        end
        checks++;
        if (aq.size() != N) begin
            failures++;
            $display("FAIL %s enb_pulses: got %0d want %0d", tag, aq.size(), N);
        end
        for (int i = 0; i < N && i < aq.size(); i++) begin
            mask = (64'd1 << (4 * i)) - 64'd1;
            cr   = ((longint'(a) & mask) + (longint'(b) & mask) + longint'(c)) >> (4 * i);
            checks++;
            if (aq[i] !== a[4*i +: 4] || bq[i] !== b[4*i +: 4] || rq[i] !== cr[0]) begin
                failures++;
                $display("FAIL %s nibble%0d: got A=%h B=%h RCI=%b want A=%h B=%h RCI=%b",
                         tag, i, aq[i], bq[i], rq[i], a[4*i +: 4], b[4*i +: 4], cr[0]);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        START = 1'b1;
        OPA   = 16'hABCD;
        OPB   = 16'h1111;
        CIN   = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || ENB !== 1'b0 || RESULT !== '0 || COUT !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got busy=%b done=%b enb=%b res=%h cout=%b want all zero",
                     BUSY, DONE, ENB, RESULT, COUT);
        end
        checks++;
        if (A !== 4'd0 || B !== 4'd0 || RCI !== 1'b0 || MODO !== 2'b00) begin
            failures++;
            $display("FAIL reset_slice: got A=%h B=%h RCI=%b MODO=%b want 0 0 0 00", A, B, RCI, MODO);
        end
        RESET = 1'b0;
        START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000};
        logic [W-1:0] tb[4] = '{16'h4321, 16'h0001, 16'h0000, 16'h8000};
        logic         tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] held;
        for (int k = 0; k < 4; k++) begin
            run_op(ta[k], tb[k], tc[k], $sformatf("directed%0d", k));
            held = RESULT;
            @(negedge CLK);
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || RESULT !== held) begin
                failures++;
                $display("FAIL directed%0d after_done: got done=%b busy=%b res=%h want 0 0 %h",
                         k, DONE, BUSY, RESULT, held);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("random%0d", k));
            @(negedge CLK);
        end
    endtask

    task automatic test_start_held();
        logic [W:0]   expq[$];
        logic [W:0]   e;
        logic [W-1:0] da;
        logic [W-1:0] db;
        logic         dc;
        logic         prev_busy;
        int           dones;
        int           accs;
        int           last_done;
        prev_busy = 1'b0;
        dones     = 0;
        accs      = 0;
        last_done = -100;
        da = W'($urandom); db = W'($urandom); dc = 1'($urandom);
        START = 1'b1; OPA = da; OPB = db; CIN = dc;
        for (int k = 0; k < 70; k++) begin
            @(negedge CLK);
            if (BUSY && !prev_busy) begin
                expq.push_back({1'b0, da} + {1'b0, db} + {{W{1'b0}}, dc});
                accs++;
            end
            if (DONE) begin
                dones++;
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL held_done: got unexpected DONE at cycle %0d want none", k);
                end else begin
                    e = expq.pop_front();
                    if (RESULT !== e[W-1:0] || COUT !== e[W]) begin
                        failures++;
                        $display("FAIL held_result: got %h/%b want %h/%b", RESULT, COUT, e[W-1:0], e[W]);
                    end
                end
                checks++;
                if (k - last_done < 2 * N + 1) begin
                    failures++;
                    $display("FAIL held_spacing: got %0d cycles want >= %0d", k - last_done, 2 * N + 1);
                end
                last_done = k;
            end
            prev_busy = BUSY;
            da = W'($urandom); db = W'($urandom); dc = 1'($urandom);
            START = (k < 49);
            OPA = da; OPB = db; CIN = dc;
        end
        checks++;
        if (dones != accs || dones < 4) begin
            failures++;
            $display("FAIL held_count: got %0d dones for %0d accepts want equal and >= 4", dones, accs);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        START = 1'b1; OPA = 16'h1234; OPB = 16'h4321; CIN = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        RESET = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || ENB !== 1'b0 || RESULT !== '0 || COUT !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL abort: got busy=%b enb=%b res=%h cout=%b done=%b want all zero",
                     BUSY, ENB, RESULT, COUT, DONE);
        end
        RESET = 1'b0;
        START = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL abort_done: got %0d DONE pulses want 0", dones);
        end
        run_op(16'hBEEF, 16'h4111, 1'b1, "after_abort");
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        run_op(16'h0F0F, 16'h0101, 1'b0, "b2b_first");
        START = 1'b1;
        OPA   = 16'hDEAD;
        OPB   = 16'hDEAD;
        CIN   = 1'b1;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL fin_start_ignored: got busy=%b done=%b want 0 0", BUSY, DONE);
        end
        run_op(16'h7FFF, 16'h0001, 1'b1, "b2b_second");
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b0;
        START = 1'b0;
        OPA   = '0;
        OPB   = '0;
        CIN   = 1'b0;
        @(negedge CLK);
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
